wide_seq_alu: RTL and testbench
===============================

WIDE_SEQ_ALU -- requirements
Module: wide_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 100, operand/result width in bits (>=1).
REQ-002 SHALL have parameter CHUNK, default 16, bits processed per cycle (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 REDAND, 7 REDOR.
REQ-008 SHALL have ports x, y  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at clk edge.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port carry  output  1  ADD carry-out / SUB no-borrow; 0 for other ops.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE; IDLE: in_ready=1; accept -> RUN, chunk index 0.
REQ-014 SHALL register op, x, y on accept; input changes during RUN/DONE are ignored.
REQ-015 SHALL process one CHUNK slice per RUN cycle, LSB first; after slice NCHUNK-1 -> DONE.
REQ-016 SHALL assert out_valid exactly NCHUNK clock edges after the accepting edge; latency is op-independent.
REQ-017 SHALL propagate ADD/SUB carry between slices in a 1-bit register; SUB = x + ~y + 1, carry=1 iff x>=y unsigned.
REQ-018 SHALL take carry from bit position WIDTH; final partial slice (WIDTH mod CHUNK != 0) processes only valid bits.
REQ-019 SHALL compute AND/OR/XOR bitwise per slice.
REQ-020 SHALL compute SHL as x << y with full-width y; y >= WIDTH (any bit set above log2 range) yields 0; full result may be formed in the first RUN cycle and held.
REQ-021 SHALL accumulate REDAND/REDOR across slices; result = {WIDTH-1 zeros, reduction bit}.
REQ-022 SHALL hold result, carry, out_valid stable in DONE while out_ready=0; in_ready=0 in RUN and in DONE when out_ready=0.
REQ-023 SHALL drive in_ready = 1 in DONE when out_ready=1; simultaneous accept there goes directly to RUN (no IDLE bubble).
REQ-024 SHALL, on consume without new accept, go DONE -> IDLE with out_valid=0 next cycle.
REQ-025 SHALL produce result bits identical to the equivalent combinational Verilog expression mod 2^WIDTH.

Reset
REQ-026 SHALL on rst_n=0 immediately force: state IDLE, in_ready=1 after FSM decode, out_valid=0, result=0, carry=0, chunk index 0.
REQ-027 SHALL abort any in-flight operation on reset mid-RUN/DONE; no partial result is ever presented.

Structure
REQ-028 SHALL place opcode constants and FSM state encodings in shared package wide_alu_pkg.
REQ-029 SHALL use one sub-module wide_alu_slice (CHUNK-bit combinational slice: add/sub with carry-in/out, bitwise, reduction partial).
REQ-030 SHALL fit in 120-400 lines of RTL; no multi-cycle paths, no latches.

Verification (WIDTH=100, CHUNK=16, NCHUNK=7)
REQ-031 ADD x=1 y=2 -> result=3, carry=0, out_valid 7 edges after accept.
REQ-032 ADD x=2^100-1 y=1 -> result=0, carry=1 (ripple through all slices incl. 4-bit last slice).
REQ-033 SUB x=5 y=7 -> result=2^100-2, carry=0; SUB x=7 y=7 -> 0, carry=1.
REQ-034 SHL x=1 y=2^64+1 -> result=0; SHL x=1 y=65 -> result=2^65; REDAND x=all-ones -> 1; REDOR x=0 -> 0.
REQ-035 Back-pressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge.
REQ-036 Reset pulse at RUN cycle 3 -> out_valid=0 immediately, in_ready=1 after release; next ADD x=7 y=2 -> 9.

Source files
------------

// File: rtl/wide_alu_pkg.sv
// wide_alu_pkg: opcode and FSM state encodings shared by the wide sequential ALU
package wide_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_REDAND, OP_REDOR
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/wide_alu_slice.sv
// wide_alu_slice: one CHUNK-bit combinational slice (add/sub with carry, bitwise, reduction partials)
module wide_alu_slice
  import wide_alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  op_e              op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [CHUNK-1:0] mask,
  input  logic             cin,
  output logic [CHUNK-1:0] r,
  output logic             cout,
  output logic             red_and,
  output logic             red_or
);
  logic [CHUNK-1:0] am, bm;
  logic [CHUNK:0] sum, top;
  always_comb begin
    am = a & mask;
    bm = (op == OP_SUB ? ~b : b) & mask;
    sum = {1'b0, am} + {1'b0, bm} + {{CHUNK{1'b0}}, cin};
    top = {mask, 1'b1} & ~{1'b0, mask};
    cout = |(sum & top);
    r = (op == OP_ADD || op == OP_SUB ? sum[CHUNK-1:0] :
         op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b) & mask;
    red_and = &(a | ~mask);
    red_or = |(a & mask);
  end
endmodule

// File: rtl/wide_seq_alu.sv
// wide_seq_alu: multi-cycle WIDTH-bit ALU processing one CHUNK slice per cycle, LSB first
module wide_seq_alu
  import wide_alu_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW = NCHUNK * CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int LAST_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam logic [CHUNK:0] LAST_ONE = (CHUNK + 1)'(1) << LAST_BITS;
  localparam logic [CHUNK-1:0] LAST_MASK = CHUNK'(LAST_ONE - 1'b1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic cy_q, cy_d, red_q, red_d;
  logic [NCHUNK-1:0][CHUNK-1:0] xc, yc;
  logic [CHUNK-1:0] sl_a, sl_b, sl_mask, sl_r;
  logic sl_cin, sl_cout, sl_and, sl_or, last, accept;
  assign xc = PW'(x_q);
  assign yc = PW'(y_q);
  assign in_ready = state_q == S_IDLE || (state_q == S_DONE && out_ready);
  assign out_valid = state_q == S_DONE;
  assign result = out_valid ? res_q : '0;
  assign carry = out_valid && (op_q == OP_ADD || op_q == OP_SUB) && cy_q;
  always_comb begin
    last = idx_q == IW'(NCHUNK - 1);
    sl_a = xc[idx_q];
    sl_b = yc[idx_q];
    sl_mask = last ? LAST_MASK : '1;
    sl_cin = idx_q == '0 ? op_q == OP_SUB : cy_q;
  end
  wide_alu_slice #(.CHUNK(CHUNK)) u_slice (
    .op(op_q), .a(sl_a), .b(sl_b), .mask(sl_mask), .cin(sl_cin),
    .r(sl_r), .cout(sl_cout), .red_and(sl_and), .red_or(sl_or)
  );
  always_comb begin
    accept = in_valid && in_ready;
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    x_d = x_q;
    y_d = y_q;
    res_d = res_q;
    cy_d = cy_q;
    red_d = red_q;
    if (state_q == S_RUN) begin
      cy_d = sl_cout;
      red_d = op_q == OP_REDAND ? (idx_q == '0 || red_q) && sl_and : (idx_q != '0 && red_q) || sl_or;
      idx_d = last ? '0 : idx_q + IW'(1);
      state_d = last ? S_DONE : S_RUN;
      if (op_q == OP_SHL) res_d = x_q << y_q;
      else if (op_q == OP_REDAND || op_q == OP_REDOR) res_d = WIDTH'(red_d);
      else for (int i = 0; i < WIDTH; i++) if (i / CHUNK == int'(idx_q)) res_d[i] = sl_r[i % CHUNK];
    end
    if (state_q == S_DONE && out_ready) state_d = S_IDLE;
    if (accept) begin
      state_d = S_RUN;
      idx_d = '0;
      op_d = op_e'(op);
      x_d = x;
      y_d = y;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= OP_ADD;
      idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      res_q <= '0;
      cy_q <= 1'b0;
      red_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      x_q <= x_d;
      y_q <= y_d;
      res_q <= res_d;
      cy_q <= cy_d;
      red_q <= red_d;
    end
  end
endmodule

// File: tb/tb_wide_seq_alu.sv
// tb_wide_seq_alu: directed plus random checks of wide_seq_alu against an arithmetic reference model
module tb_wide_seq_alu;
  localparam int W = 100;
  localparam int LAT = 7;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] x = '0, y = '0;
  logic in_ready, out_valid, carry;
  logic [W-1:0] result;
  int checks = 0, errors = 0;
  wide_seq_alu #(.WIDTH(W), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom, $urandom, $urandom});
  endfunction
  function automatic logic [W:0] model(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      0: return {1'b0, a} + {1'b0, b};
      1: return {a >= b, a - b};
      2: return {1'b0, a & b};
      3: return {1'b0, a | b};
      4: return {1'b0, a ^ b};
      5: return {1'b0, a << b};
      6: return (W + 1)'(&a);
      7: return (W + 1)'(|a);
      default: return '0;
    endcase
  endfunction
  task automatic start_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    op = 3'(o);
    x = a;
    y = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    x = rnd();
    y = rnd();
    check("in_ready_in_run", 128'(in_ready), 128'(0));
  endtask
  task automatic wait_result(input string tag, input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = model(o, a, b);
    check({tag, "_latency"}, 128'(n), 128'(LAT));
    check({tag, "_result"}, 128'(result), 128'(e[W-1:0]));
    check({tag, "_carry"}, 128'(carry), 128'(e[W]));
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_consume", 128'(out_valid), 128'(0));
  endtask
  task automatic full_op(input string tag, input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(o, a, b);
    wait_result(tag, o, a, b);
    consume();
  endtask
  initial begin
    logic [W-1:0] a, b, big, r0;
    int o;
    #12;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_result", 128'(result), 128'(0));
    check("rst_carry", 128'(carry), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    full_op("add_1_2", 0, W'(1), W'(2));
    full_op("add_ripple", 0, '1, W'(1));
    full_op("sub_5_7", 1, W'(5), W'(7));
    full_op("sub_7_7", 1, W'(7), W'(7));
    big = (W'(1) << 64) | W'(1);
    full_op("shl_big", 5, W'(1), big);
    full_op("shl_65", 5, W'(1), W'(65));
    full_op("shl_99", 5, '1, W'(99));
    full_op("redand_ones", 6, '1, '0);
    full_op("redand_topzero", 6, {1'b0, {(W - 1){1'b1}}}, '0);
    full_op("redor_zero", 7, '0, '0);
    full_op("redor_top", 7, {1'b1, {(W - 1){1'b0}}}, '0);
    full_op("xor_rand", 4, rnd(), rnd());
    a = rnd();
    b = rnd();
    start_op(0, a, b);
    wait_result("bp_first", 0, a, b);
    r0 = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", 128'(result), 128'(r0));
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_hold_in_ready", 128'(in_ready), 128'(0));
    end
    a = rnd();
    b = rnd();
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 3'(1);
    x = a;
    y = b;
    #1;
    check("bp_in_ready_done", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = rnd();
    check("bp_back_to_back_run", 128'(out_valid), 128'(0));
    wait_result("bp_second", 1, a, b);
    consume();
    start_op(0, rnd(), rnd());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_result", 128'(result), 128'(0));
    check("midrst_carry", 128'(carry), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_out_valid", 128'(out_valid), 128'(0));
    check("postrst_in_ready", 128'(in_ready), 128'(1));
    full_op("add_7_2", 0, W'(7), W'(2));
    for (int i = 0; i < 32; i++) begin
      o = $urandom_range(0, 7);
      a = rnd();
      b = rnd();
      if (o == 5 && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 110));
      if (o == 1 && $urandom_range(0, 3) == 0) b = a;
      if (o == 6 && $urandom_range(0, 1) == 1) a = '1;
      if (o == 7 && $urandom_range(0, 1) == 1) a = '0;
      full_op("random", o, a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
